// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, bit indices, cause codes, FSM states.
// No logic; imported by csr_unit and csr_counters.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [5:0] CAUSE_ILLEGAL_INSTR    = 6'd2;
  localparam logic [5:0] CAUSE_BREAKPOINT       = 6'd3;
  localparam logic [5:0] CAUSE_LOAD_MISALIGNED  = 6'd4;
  localparam logic [5:0] CAUSE_STORE_MISALIGNED = 6'd6;
  localparam logic [5:0] CAUSE_M_TIMER          = 6'd7;
  localparam logic [5:0] CAUSE_ECALL_M          = 6'd11;
  localparam logic [5:0] CAUSE_M_EXT            = 6'd11;

  // RV64 (MXL=2) with the I base extension
  localparam logic [63:0] MISA_VAL = {2'b10, 36'd0, 26'h000_0100};

  typedef enum logic {RUN, REDIR} csr_state_e;

  function automatic logic [63:0] trap_target(input logic [63:0] mtvec,
                                              input logic        is_irq,
                                              input logic [5:0]  code);
    logic [63:0] base;
    base = {mtvec[63:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && is_irq)
      return base + {56'd0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/csr_counters.sv
// mcycle/minstret counters with CSR-write override; a write that cycle beats the increment.
// Latency: written value visible the next cycle. No backpressure; always accepts writes.
module csr_counters
  import csr_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wr_vld,
  input  logic [11:0] wr_addr,
  input  logic [63:0] wr_dat,
  input  logic        retire,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  logic mcycle_wr;
  logic minstret_wr;

  assign mcycle_wr   = wr_vld && (wr_addr == CSR_MCYCLE);
  assign minstret_wr = wr_vld && (wr_addr == CSR_MINSTRET);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle_wr ? wr_dat : mcycle + 64'd1;
      if (minstret_wr)
        minstret <= wr_dat;
      else if (retire)
        minstret <= minstret + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry / MRET and a registered PC redirect to fetch.
// Latency: reads combinational, REDIRECT one cycle after CS/MRET. No backpressure.
// Counters (mcycle/minstret) are built only when CSR_COUNTERS_EN is defined.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_0000_0100,
  parameter logic [63:0] HART_ID     = 64'd0
)
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WB_LD_CSR,
  input  logic [11:0] WB_CSR_ADDR,
  input  logic [63:0] WB_CSR_DATA,
  input  logic [11:0] RD_CSR_ADDR,
  output logic [63:0] RD_CSR_DATA,
  output logic        ILLEGAL_CSR,
  input  logic        CS,
  input  logic [63:0] CAUSE,
  input  logic [63:0] TRAP_PC,
  input  logic [63:0] TRAP_VAL,
  input  logic        MRET,
  input  logic        WB_RETIRE,
  input  logic        TIMER_IRQ,
  input  logic        EXT_IRQ,
  output logic        INT_PENDING,
  output logic        REDIRECT,
  output logic [63:0] REDIRECT_PC
);

  csr_state_e  state_q, state_d;
  logic        take_trap, take_mret;

  logic        mstatus_mie, mstatus_mpie;
  logic        mie_mtie, mie_meie;
  logic        mip_mtip, mip_meip;
  logic [63:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;

  logic        wr_vld;
  logic        wr_blocked;

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= RUN;
    else        state_q <= state_d;
  end

  // CS and MRET are only honoured in RUN; in REDIR the pipeline is flushing
  always_comb begin
    state_d   = state_q;
    take_trap = 1'b0;
    take_mret = 1'b0;
    REDIRECT  = 1'b0;
    case (state_q)
      RUN: begin
        if (CS) begin
          take_trap = 1'b1;
          state_d   = REDIR;
        end else if (MRET) begin
          take_mret = 1'b1;
          state_d   = REDIR;
        end
      end
      REDIR: begin
        REDIRECT = 1'b1;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A CSR write loses only where the trap or MRET updates the same register
  always_comb begin
    wr_blocked = 1'b0;
    if (take_trap)
      wr_blocked = (WB_CSR_ADDR == CSR_MSTATUS) || (WB_CSR_ADDR == CSR_MEPC) ||
                   (WB_CSR_ADDR == CSR_MCAUSE)  || (WB_CSR_ADDR == CSR_MTVAL);
    else if (take_mret)
      wr_blocked = (WB_CSR_ADDR == CSR_MSTATUS);
  end

  assign wr_vld = WB_LD_CSR && !wr_blocked;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mip_mtip     <= 1'b0;
      mip_meip     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
      REDIRECT_PC  <= '0;
      INT_PENDING  <= 1'b0;
    end else begin
      if (take_trap) begin
        mepc         <= {TRAP_PC[63:2], 2'b00};
        mcause       <= CAUSE;
        mtval        <= TRAP_VAL;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        REDIRECT_PC  <= trap_target(mtvec, CAUSE[63], CAUSE[5:0]);
      end else if (take_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
        REDIRECT_PC  <= mepc;
      end

      if (wr_vld) begin
        case (WB_CSR_ADDR)
          CSR_MSTATUS: begin
            mstatus_mie  <= WB_CSR_DATA[MSTATUS_MIE];
            mstatus_mpie <= WB_CSR_DATA[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            mie_mtie <= WB_CSR_DATA[MIP_MTIP];
            mie_meie <= WB_CSR_DATA[MIP_MEIP];
          end
          // MODE values 2 and 3 are reserved and collapse to direct
          CSR_MTVEC:    mtvec    <= {WB_CSR_DATA[63:2], 1'b0, (WB_CSR_DATA[1:0] == 2'b01)};
          CSR_MSCRATCH: mscratch <= WB_CSR_DATA;
          CSR_MEPC:     mepc     <= {WB_CSR_DATA[63:2], 2'b00};
          CSR_MCAUSE:   mcause   <= WB_CSR_DATA;
          CSR_MTVAL:    mtval    <= WB_CSR_DATA;
          default: ;
        endcase
      end

      mip_mtip    <= TIMER_IRQ;
      mip_meip    <= EXT_IRQ;
      INT_PENDING <= mstatus_mie & ((mie_mtie & mip_mtip) | (mie_meie & mip_meip));
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counters u_counters (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .wr_vld   (WB_LD_CSR),
    .wr_addr  (WB_CSR_ADDR),
    .wr_dat   (WB_CSR_DATA),
    .retire   (WB_RETIRE),
    .mcycle   (mcycle),
    .minstret (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = WB_RETIRE;
  assign mcycle        = '0;
  assign minstret      = '0;
`endif

  always_comb begin
    RD_CSR_DATA = '0;
    ILLEGAL_CSR = 1'b0;
    case (RD_CSR_ADDR)
      CSR_MSTATUS: begin
        RD_CSR_DATA[12:11]          = 2'b11;
        RD_CSR_DATA[MSTATUS_MPIE]   = mstatus_mpie;
        RD_CSR_DATA[MSTATUS_MIE]    = mstatus_mie;
      end
      CSR_MISA:     RD_CSR_DATA = MISA_VAL;
      CSR_MIE: begin
        RD_CSR_DATA[MIP_MTIP] = mie_mtie;
        RD_CSR_DATA[MIP_MEIP] = mie_meie;
      end
      CSR_MTVEC:    RD_CSR_DATA = mtvec;
      CSR_MSCRATCH: RD_CSR_DATA = mscratch;
      CSR_MEPC:     RD_CSR_DATA = mepc;
      CSR_MCAUSE:   RD_CSR_DATA = mcause;
      CSR_MTVAL:    RD_CSR_DATA = mtval;
      CSR_MIP: begin
        RD_CSR_DATA[MIP_MTIP] = mip_mtip;
        RD_CSR_DATA[MIP_MEIP] = mip_meip;
      end
      CSR_MHARTID:  RD_CSR_DATA = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   RD_CSR_DATA = mcycle;
      CSR_MINSTRET: RD_CSR_DATA = minstret;
`endif
      default:      ILLEGAL_CSR = 1'b1;
    endcase
  end

endmodule
